// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: seconds/minutes/hours/days clock with
// time load, event timestamp latch and one-shot alarm.
module rtc_timekeeper #(
  parameter int HOUR_MOD = 24,
  parameter int HOUR_W   = 5,
  parameter int DAY_W    = 8
) (
  input  logic              clk_1Hz,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [5:0]        load_sec,
  input  logic [5:0]        load_min,
  input  logic [HOUR_W-1:0] load_hour,
  input  logic              event_strobe,
  input  logic              ev_ack,
  input  logic              alarm_set,
  input  logic              alarm_clr,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [5:0]        alarm_min,
  output logic [5:0]        seconds,
  output logic [5:0]        minutes,
  output logic [HOUR_W-1:0] hours,
  output logic [DAY_W-1:0]  days,
  output logic [5:0]        ev_sec,
  output logic [5:0]        ev_min,
  output logic [HOUR_W-1:0] ev_hour,
  output logic              ev_valid,
  output logic              ev_overrun,
  output logic              load_err,
  output logic              alarm_hit,
  output logic              day_tick
);

  localparam logic [5:0] LAST_60 = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_LAST =
    HOUR_W'(HOUR_MOD - 1);
  localparam logic [31:0] HOUR_LIM = 32'(HOUR_MOD);

  logic              alarm_armed;
  logic [HOUR_W-1:0] alarm_hour_q;
  logic [5:0]        alarm_min_q;

  logic              sec_wrap;
  logic              min_wrap;
  logic              hour_wrap;
  logic [5:0]        cnt_sec;
  logic [5:0]        cnt_min;
  logic [HOUR_W-1:0] cnt_hour;

  logic              load_ok;
  logic              alarm_ok;
  logic              do_load;
  logic              bad_load;
  logic              do_count;
  logic              alarm_match;

  // field range checks for load and alarm arming
  always_comb begin
    load_ok  = (load_sec <= LAST_60) &&
               (load_min <= LAST_60) &&
               (32'(load_hour) < HOUR_LIM);
    alarm_ok = (alarm_min <= LAST_60) &&
               (32'(alarm_hour) < HOUR_LIM);
    do_load  = load && load_ok;
    bad_load = load && !load_ok;
    do_count = enable && !load;
  end

  // ripple carry of the next counted time
  always_comb begin
    sec_wrap  = (seconds == LAST_60);
    min_wrap  = sec_wrap && (minutes == LAST_60);
    hour_wrap = min_wrap && (hours == HOUR_LAST);
    cnt_sec   = sec_wrap ? 6'd0 : seconds + 6'd1;
    cnt_min   = minutes;
    if (sec_wrap) begin
      cnt_min = min_wrap ? 6'd0 : minutes + 6'd1;
    end
    cnt_hour  = hours;
    if (min_wrap) begin
      cnt_hour = hour_wrap ? '0 : hours + HOUR_W'(1);
    end
  end

  // alarm compares against the time a count step is about to show
  always_comb begin
    alarm_match = alarm_armed &&
                  (cnt_hour == alarm_hour_q) &&
                  (cnt_min == alarm_min_q) &&
                  (cnt_sec == 6'd0);
  end

  // time registers: load beats count beats hold
  always_ff @(posedge clk_1Hz) begin
    if (reset) begin
      seconds <= '0;
      minutes <= '0;
      hours   <= '0;
    end else if (do_load) begin
      seconds <= load_sec;
      minutes <= load_min;
      hours   <= load_hour;
    end else if (do_count) begin
      seconds <= cnt_sec;
      minutes <= cnt_min;
      hours   <= cnt_hour;
    end
  end

  // day counter advances on a counted hour wrap
  always_ff @(posedge clk_1Hz) begin
    if (reset) begin
      days <= '0;
    end else if (do_count && hour_wrap) begin
      days <= days + DAY_W'(1);
    end
  end

  // single-cycle status pulses aligned with the new time
  always_ff @(posedge clk_1Hz) begin
    if (reset) begin
      load_err  <= 1'b0;
      day_tick  <= 1'b0;
      alarm_hit <= 1'b0;
    end else begin
      load_err  <= bad_load;
      day_tick  <= do_count && hour_wrap;
      alarm_hit <= do_count && alarm_match;
    end
  end

  // event latch captures pre-update time, newest wins
  always_ff @(posedge clk_1Hz) begin
    if (reset) begin
      ev_sec     <= '0;
      ev_min     <= '0;
      ev_hour    <= '0;
      ev_valid   <= 1'b0;
      ev_overrun <= 1'b0;
    end else if (event_strobe) begin
      ev_sec   <= seconds;
      ev_min   <= minutes;
      ev_hour  <= hours;
      ev_valid <= 1'b1;
      if (ev_valid && !ev_ack) begin
        ev_overrun <= 1'b1;
      end
    end else if (ev_ack) begin
      ev_valid <= 1'b0;
    end
  end

  // alarm arm/disarm; a valid set wins over clear
  always_ff @(posedge clk_1Hz) begin
    if (reset) begin
      alarm_armed  <= 1'b0;
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
    end else if (alarm_set && alarm_ok) begin
      alarm_armed  <= 1'b1;
      alarm_hour_q <= alarm_hour;
      alarm_min_q  <= alarm_min;
    end else if (alarm_clr) begin
      alarm_armed  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: vector table, corner sequences and
// random stimulus against a seconds-of-day reference model.
module tb_rtc_timekeeper;

  logic clk_1Hz = 1'b0;
  always #5 clk_1Hz = ~clk_1Hz;

  logic       reset, enable, load;
  logic [5:0] load_sec, load_min;
  logic [4:0] load_hour;
  logic       event_strobe, ev_ack;
  logic       alarm_set, alarm_clr;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;

  logic [5:0] sec_a, min_a, esec_a, emin_a;
  logic [4:0] hour_a, ehour_a;
  logic [7:0] days_a;
  logic       evv_a, ovr_a, lerr_a, hit_a, tick_a;

  logic [5:0] sec_b, min_b, esec_b, emin_b;
  logic [4:0] hour_b, ehour_b;
  logic [2:0] days_b;
  logic       evv_b, ovr_b, lerr_b, hit_b, tick_b;

  rtc_timekeeper #(
    .HOUR_MOD(24), .HOUR_W(5), .DAY_W(8)
  ) u_a (
    .clk_1Hz(clk_1Hz), .reset(reset), .enable(enable),
    .load(load), .load_sec(load_sec),
    .load_min(load_min), .load_hour(load_hour),
    .event_strobe(event_strobe), .ev_ack(ev_ack),
    .alarm_set(alarm_set), .alarm_clr(alarm_clr),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .seconds(sec_a), .minutes(min_a), .hours(hour_a),
    .days(days_a), .ev_sec(esec_a), .ev_min(emin_a),
    .ev_hour(ehour_a), .ev_valid(evv_a),
    .ev_overrun(ovr_a), .load_err(lerr_a),
    .alarm_hit(hit_a), .day_tick(tick_a)
  );

  rtc_timekeeper #(
    .HOUR_MOD(12), .HOUR_W(5), .DAY_W(3)
  ) u_b (
    .clk_1Hz(clk_1Hz), .reset(reset), .enable(enable),
    .load(load), .load_sec(load_sec),
    .load_min(load_min), .load_hour(load_hour),
    .event_strobe(event_strobe), .ev_ack(ev_ack),
    .alarm_set(alarm_set), .alarm_clr(alarm_clr),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .seconds(sec_b), .minutes(min_b), .hours(hour_b),
    .days(days_b), .ev_sec(esec_b), .ev_min(emin_b),
    .ev_hour(ehour_b), .ev_valid(evv_b),
    .ev_overrun(ovr_b), .load_err(lerr_b),
    .alarm_hit(hit_b), .day_tick(tick_b)
  );

  typedef struct {
    bit rst, en, ld;
    int lh, lm, ls;
    bit stb, ack, aset, aclr;
    int ah, am;
  } stim_t;

  typedef struct {
    int tod, days, ev_tod;
    bit evv, ovr, lerr, hit, tick, armed;
    int ah, am;
  } mdl_t;

  typedef struct {
    int h, m, s, d, eh, em, es;
    bit evv, ovr, lerr, hit, tick;
  } exp_t;

  typedef struct {
    stim_t in;
    exp_t  ex;
  } vec_t;

  int checks = 0;
  int failures = 0;
  mdl_t m24, m12;
  vec_t tbl[$];

  task automatic chk(string name, logic [31:0] act,
                     int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic stim_t st(
    bit rst, bit en, bit ld, int lh, int lm, int ls,
    bit stb, bit ack, bit aset, bit aclr,
    int ah, int am);
    stim_t v;
    v.rst = rst; v.en = en; v.ld = ld;
    v.lh = lh; v.lm = lm; v.ls = ls;
    v.stb = stb; v.ack = ack;
    v.aset = aset; v.aclr = aclr;
    v.ah = ah; v.am = am;
    return v;
  endfunction

  function automatic exp_t ex(
    int h, int m, int s, int d, int eh, int em, int es,
    bit evv, bit ovr, bit lerr, bit hit, bit tick);
    exp_t e;
    e.h = h; e.m = m; e.s = s; e.d = d;
    e.eh = eh; e.em = em; e.es = es;
    e.evv = evv; e.ovr = ovr; e.lerr = lerr;
    e.hit = hit; e.tick = tick;
    return e;
  endfunction

  function automatic void add(stim_t v, exp_t e);
    vec_t t;
    t.in = v;
    t.ex = e;
    tbl.push_back(t);
  endfunction

  // reference: time as seconds-of-day, one step per clock
  function automatic mdl_t step(mdl_t s, stim_t v,
                                int mod, int dw);
    mdl_t n;
    n = s;
    n.lerr = 0; n.hit = 0; n.tick = 0;
    if (v.rst) begin
      n = '{default: 0};
      return n;
    end
    if (v.ld) begin
      if (v.lh < mod && v.lm < 60 && v.ls < 60)
        n.tod = v.lh * 3600 + v.lm * 60 + v.ls;
      else
        n.lerr = 1;
    end else if (v.en) begin
      n.tod = (s.tod + 1) % (mod * 3600);
      if (n.tod == 0) begin
        n.tick = 1;
        n.days = (s.days + 1) % (1 << dw);
      end
      if (s.armed && n.tod == s.ah * 3600 + s.am * 60)
        n.hit = 1;
    end
    if (v.aset && v.ah < mod && v.am < 60) begin
      n.armed = 1; n.ah = v.ah; n.am = v.am;
    end else if (v.aclr) begin
      n.armed = 0;
    end
    if (v.stb) begin
      n.ev_tod = s.tod;
      n.evv = 1;
      if (s.evv && !v.ack) n.ovr = 1;
    end else if (v.ack) begin
      n.evv = 0;
    end
    return n;
  endfunction

  task automatic chk_model(
    string p, mdl_t m,
    logic [5:0] s, logic [5:0] mi, logic [4:0] h,
    logic [7:0] d, logic [5:0] es, logic [5:0] em,
    logic [4:0] eh, logic evv, logic ovr,
    logic lerr, logic hit, logic tick);
    chk({p, ".sec"}, 32'(s), m.tod % 60);
    chk({p, ".min"}, 32'(mi), (m.tod / 60) % 60);
    chk({p, ".hour"}, 32'(h), m.tod / 3600);
    chk({p, ".days"}, 32'(d), m.days);
    chk({p, ".ev_sec"}, 32'(es), m.ev_tod % 60);
    chk({p, ".ev_min"}, 32'(em), (m.ev_tod / 60) % 60);
    chk({p, ".ev_hour"}, 32'(eh), m.ev_tod / 3600);
    chk({p, ".ev_valid"}, 32'(evv), int'(m.evv));
    chk({p, ".ev_overrun"}, 32'(ovr), int'(m.ovr));
    chk({p, ".load_err"}, 32'(lerr), int'(m.lerr));
    chk({p, ".alarm_hit"}, 32'(hit), int'(m.hit));
    chk({p, ".day_tick"}, 32'(tick), int'(m.tick));
  endtask

  task automatic drive(stim_t v);
    reset = v.rst; enable = v.en; load = v.ld;
    load_sec = 6'(v.ls); load_min = 6'(v.lm);
    load_hour = 5'(v.lh);
    event_strobe = v.stb; ev_ack = v.ack;
    alarm_set = v.aset; alarm_clr = v.aclr;
    alarm_hour = 5'(v.ah); alarm_min = 6'(v.am);
    @(posedge clk_1Hz);
    m24 = step(m24, v, 24, 8);
    m12 = step(m12, v, 12, 3);
    #1;
    chk_model("a", m24, sec_a, min_a, hour_a, days_a,
              esec_a, emin_a, ehour_a, evv_a, ovr_a,
              lerr_a, hit_a, tick_a);
    chk_model("b", m12, sec_b, min_b, hour_b,
              8'(days_b), esec_b, emin_b, ehour_b,
              evv_b, ovr_b, lerr_b, hit_b, tick_b);
  endtask

  function automatic stim_t rnd();
    stim_t v;
    int cur;
    v = st(0,0,0, 0,0,0, 0,0,0,0, 0,0);
    v.rst = ($urandom_range(0, 299) == 0);
    v.en  = ($urandom_range(0, 9) < 8);
    if ($urandom_range(0, 19) == 0) begin
      v.ld = 1;
      if ($urandom_range(0, 7) == 0) begin
        v.lh = $urandom_range(0, 31);
        v.lm = $urandom_range(0, 63);
        v.ls = $urandom_range(0, 63);
      end else begin
        v.lh = $urandom_range(0, 11);
        v.lm = ($urandom_range(0, 1) == 1) ? 59 :
               $urandom_range(0, 59);
        v.ls = $urandom_range(45, 59);
      end
    end
    v.stb = ($urandom_range(0, 7) == 0);
    v.ack = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 29) == 0) begin
      v.aset = 1;
      cur = m12.tod + 60;
      v.ah = (cur / 3600) % 12;
      v.am = (cur / 60) % 60;
      if ($urandom_range(0, 4) == 0) begin
        v.ah = $urandom_range(0, 31);
        v.am = $urandom_range(0, 63);
      end
    end
    v.aclr = ($urandom_range(0, 59) == 0);
    return v;
  endfunction

  initial begin
    exp_t e;
    stim_t idl, en1;
    m24 = '{default: 0};
    m12 = '{default: 0};
    idl = st(0,0,0, 0,0,0, 0,0,0,0, 0,0);
    en1 = st(0,1,0, 0,0,0, 0,0,0,0, 0,0);

    add(en1, ex(0,1,15,0, 0,0,0, 0,0,0,0,0));
    add(st(0,1,1, 23,59,58, 0,0,0,0, 0,0),
        ex(23,59,58,0, 0,0,0, 0,0,0,0,0));
    add(en1, ex(23,59,59,0, 0,0,0, 0,0,0,0,0));
    add(en1, ex(0,0,0,1, 0,0,0, 0,0,0,0,1));
    add(en1, ex(0,0,1,1, 0,0,0, 0,0,0,0,0));
    for (int s = 2; s <= 5; s++)
      add(en1, ex(0,0,s,1, 0,0,0, 0,0,0,0,0));
    add(st(0,1,0, 0,0,0, 1,0,0,0, 0,0),
        ex(0,0,6,1, 0,0,5, 1,0,0,0,0));
    for (int s = 7; s <= 9; s++)
      add(en1, ex(0,0,s,1, 0,0,5, 1,0,0,0,0));
    add(st(0,1,0, 0,0,0, 1,0,0,0, 0,0),
        ex(0,0,10,1, 0,0,9, 1,1,0,0,0));
    add(st(0,0,0, 0,0,0, 0,1,0,0, 0,0),
        ex(0,0,10,1, 0,0,9, 0,1,0,0,0));
    add(st(0,0,0, 0,0,0, 1,1,0,0, 0,0),
        ex(0,0,10,1, 0,0,10, 1,1,0,0,0));
    add(st(0,0,0, 0,0,0, 1,1,0,0, 0,0),
        ex(0,0,10,1, 0,0,10, 1,1,0,0,0));
    add(st(0,1,1, 5,60,0, 0,0,0,0, 0,0),
        ex(0,0,10,1, 0,0,10, 1,1,1,0,0));
    add(idl, ex(0,0,10,1, 0,0,10, 1,1,0,0,0));
    add(st(0,0,1, 0,1,58, 0,0,1,0, 0,2),
        ex(0,1,58,1, 0,0,10, 1,1,0,0,0));
    add(en1, ex(0,1,59,1, 0,0,10, 1,1,0,0,0));
    add(en1, ex(0,2,0,1, 0,0,10, 1,1,0,1,0));
    add(en1, ex(0,2,1,1, 0,0,10, 1,1,0,0,0));
    add(st(0,0,1, 0,2,0, 0,0,0,0, 0,0),
        ex(0,2,0,1, 0,0,10, 1,1,0,0,0));
    add(st(0,0,1, 0,1,59, 0,0,0,1, 0,0),
        ex(0,1,59,1, 0,0,10, 1,1,0,0,0));
    add(en1, ex(0,2,0,1, 0,0,10, 1,1,0,0,0));
    add(st(0,0,1, 0,2,59, 0,0,1,0, 24,3),
        ex(0,2,59,1, 0,0,10, 1,1,0,0,0));
    add(en1, ex(0,3,0,1, 0,0,10, 1,1,0,0,0));
    add(st(0,0,1, 0,2,59, 0,0,1,1, 0,3),
        ex(0,2,59,1, 0,0,10, 1,1,0,0,0));
    add(en1, ex(0,3,0,1, 0,0,10, 1,1,0,1,0));
    add(st(0,0,1, 5,10,20, 0,0,0,0, 0,0),
        ex(5,10,20,1, 0,0,10, 1,1,0,0,0));
    add(st(1,1,1, 1,1,1, 1,0,1,0, 5,11),
        ex(0,0,0,0, 0,0,0, 0,0,0,0,0));
    add(st(0,0,1, 5,10,59, 0,0,0,0, 0,0),
        ex(5,10,59,0, 0,0,0, 0,0,0,0,0));
    add(en1, ex(5,11,0,0, 0,0,0, 0,0,0,0,0));

    repeat (3) drive(st(1,0,0, 0,0,0, 0,0,0,0, 0,0));
    repeat (74) drive(en1);

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      e = tbl[i].ex;
      chk($sformatf("v%0d.hour", i), 32'(hour_a), e.h);
      chk($sformatf("v%0d.min", i), 32'(min_a), e.m);
      chk($sformatf("v%0d.sec", i), 32'(sec_a), e.s);
      chk($sformatf("v%0d.days", i), 32'(days_a), e.d);
      chk($sformatf("v%0d.ev_hour", i), 32'(ehour_a), e.eh);
      chk($sformatf("v%0d.ev_min", i), 32'(emin_a), e.em);
      chk($sformatf("v%0d.ev_sec", i), 32'(esec_a), e.es);
      chk($sformatf("v%0d.ev_valid", i), 32'(evv_a),
          int'(e.evv));
      chk($sformatf("v%0d.ev_overrun", i), 32'(ovr_a),
          int'(e.ovr));
      chk($sformatf("v%0d.load_err", i), 32'(lerr_a),
          int'(e.lerr));
      chk($sformatf("v%0d.alarm_hit", i), 32'(hit_a),
          int'(e.hit));
      chk($sformatf("v%0d.day_tick", i), 32'(tick_a),
          int'(e.tick));
    end

    drive(st(0,0,1, 11,59,59, 0,0,0,0, 0,0));
    drive(en1);
    chk("m12.wrap_hour", 32'(hour_b), 0);
    chk("m12.wrap_min", 32'(min_b), 0);
    chk("m12.wrap_sec", 32'(sec_b), 0);
    chk("m12.wrap_tick", 32'(tick_b), 1);
    chk("m24.noon_hour", 32'(hour_a), 12);
    chk("m24.noon_tick", 32'(tick_a), 0);
    drive(st(0,1,1, 12,0,0, 0,0,0,0, 0,0));
    chk("m12.ld12_err", 32'(lerr_b), 1);
    chk("m12.ld12_sec", 32'(sec_b), 0);
    chk("m24.ld12_err", 32'(lerr_a), 0);
    chk("m24.ld12_hour", 32'(hour_a), 12);
    drive(idl);
    chk("m12.err_clear", 32'(lerr_b), 0);

    drive(st(1,0,0, 0,0,0, 0,0,0,0, 0,0));
    for (int k = 0; k < 7; k++) begin
      drive(st(0,0,1, 11,59,59, 0,0,0,0, 0,0));
      drive(en1);
    end
    chk("m12.days7", 32'(days_b), 7);
    drive(st(0,0,1, 11,59,59, 0,0,0,0, 0,0));
    drive(en1);
    chk("m12.days_wrap", 32'(days_b), 0);
    chk("m12.days_wrap_tick", 32'(tick_b), 1);

    for (int i = 0; i < 4000; i++) drive(rnd());

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Parametrised successor to the seconds/minutes/hours event clock in the DigiLock design.
- Adds a count enable and a synchronous time-load port.
- Adds a configurable hour modulo and a day counter.
- Adds a one-deep event timestamp latch with ack and overrun flag, plus a one-shot alarm compare.
- Sits beside the lock FSM, which strobes it on each lock event and reads back the captured time.

Parameters:
HOUR_MOD, 24, hour wrap modulo (24 or 12; 12 counts 0..11)
HOUR_W, 5, hour field width, must satisfy 2^HOUR_W >= HOUR_MOD
DAY_W, 8, day counter width; wraps at 2^DAY_W

Ports:
clk_1Hz  in  1  one-second clock
reset  in  1  synchronous, active-high
enable  in  1  count enable; advance one second per clk_1Hz edge when high
load  in  1  load time fields this cycle
load_sec  in  6  seconds value to load
load_min  in  6  minutes value to load
load_hour  in  HOUR_W  hours value to load
event_strobe  in  1  capture current time into event latch
ev_ack  in  1  consumer has read event latch
alarm_set  in  1  arm alarm with alarm_hour/alarm_min
alarm_clr  in  1  disarm alarm
alarm_hour  in  HOUR_W  alarm hour
alarm_min  in  6  alarm minute
seconds  out  6  current seconds
minutes  out  6  current minutes
hours  out  HOUR_W  current hours
days  out  DAY_W  elapsed days
ev_sec, ev_min  out  6 each  captured seconds/minutes
ev_hour  out  HOUR_W  captured hours
ev_valid  out  1  latch holds unread event
ev_overrun  out  1  sticky: strobe arrived while ev_valid=1
load_err  out  1  one-cycle pulse: load rejected
alarm_hit  out  1  one-cycle pulse on alarm match
day_tick  out  1  one-cycle pulse on hours wrap

Behaviour:
- Reset (sync, highest priority): all time, ev_* and days = 0; ev_valid, ev_overrun, load_err, alarm_hit and day_tick = 0; alarm disarmed with stored alarm fields = 0.
- Time-register priority after reset: load, then enable, then hold.
- Load, valid fields (load_sec<60, load_min<60, load_hour<HOUR_MOD):
  - Next cycle the outputs equal the loaded fields.
  - days unchanged.
  - No alarm_hit, no day_tick.
- Load, any field out of range:
  - Time unchanged for that cycle; enable is ignored in that cycle.
  - load_err=1 for exactly one cycle.
- Count (enable=1, no load):
  - seconds+1, wrapping 59->0.
  - On seconds wrap, minutes+1, wrapping 59->0.
  - On minutes wrap, hours+1, wrapping HOUR_MOD-1->0.
  - On hours wrap: days+1 modulo 2^DAY_W, and day_tick=1 in the same cycle the outputs show 0:00:00.
- enable=0: time holds, no pulses.
- Event capture:
  - event_strobe=1 registers the pre-update time (the values on the outputs during the strobe cycle) into ev_*; ev_valid=1 next cycle.
  - If ev_valid was already 1 and no ev_ack in the same cycle: capture still overwrites (newest wins) and ev_overrun is set.
  - ev_overrun clears only on reset.
  - ev_ack with no strobe: ev_valid=0; ev_* hold.
  - strobe and ack in the same cycle: capture occurs, ev_valid stays 1, no overrun.
  - Strobe on the same cycle as load or count captures the old value.
- Alarm:
  - alarm_set latches alarm_hour/alarm_min and arms; alarm_clr disarms; set wins if both are high.
  - Set with alarm_hour>=HOUR_MOD or alarm_min>=60 is ignored.
  - alarm_hit=1 for one cycle when armed and a count step (not load) makes the time equal alarm_hour:alarm_min:00; it is asserted in the same cycle the outputs show that value.
  - Alarm stays armed after a hit, so it fires again after the next wrap.
- Reset mid-operation overrides load, strobe and alarm_set in the same cycle.

Test Plan:
1. Reset 3 cycles, then enable=1 for 75 cycles -> 0:01:15; days=0; no pulses except none; ev_valid=0.
2. load 23:59:58 with enable=1 for 3 cycles -> 23:59:59, then 0:00:00 with day_tick=1 and days=1, then 0:00:01 with day_tick=0.
3. HOUR_MOD=12: load 11:59:59, one count -> 0:00:00, day_tick=1. Load load_hour=12 -> load_err pulse, time unchanged.
4. Strobe at 0:00:05 -> ev=0:00:05, ev_valid=1. Strobe at 0:00:09 without ack -> ev=0:00:09, ev_overrun=1. Ack -> ev_valid=0. Strobe+ack same cycle -> ev_valid stays 1.
5. Arm 0:02, start at 0:01:58 -> alarm_hit exactly on the 0:02:00 cycle. Load 0:02:00 directly -> no hit. alarm_clr, then count through 0:02:00 -> no hit.
6. Assert reset during load=1 and event_strobe=1 at 5:10:20 -> next cycle all outputs 0, ev_valid=0, alarm disarmed.
